// File: rtl/legv8_defs_pkg.sv
// -----------------------------------------------------------------------------
// legv8_defs_pkg
// Shared LEGv8 definitions used by the multi-cycle main control FSM and by the
// ALU control block downstream of it.
//   - Opcode constants: full 11-bit R/D-format patterns, the 8-bit CBZ prefix
//     and the 6-bit B prefix (instruction bits [31:21]).
//   - ALUOp encodings handed to ALU control.
//   - Main control state encoding.
//   - Width of the memory wait counter (covers MEM_TIMEOUT up to 255).
// -----------------------------------------------------------------------------
package legv8_defs_pkg;

    // R-format and D-format opcodes (Opcode = instr[31:21])
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CB-format and B-format prefixes; the low bits carry the offset
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    // ALUOp encodings seen by ALU control
    localparam logic [1:0]  ALUOP_ADDR  = 2'b00;  // address add
    localparam logic [1:0]  ALUOP_CBZ   = 2'b01;  // pass / compare for CBZ
    localparam logic [1:0]  ALUOP_RTYPE = 2'b10;  // funct taken from Opcode

    // Memory wait counter width
    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC_R    = 4'd3,
        ST_WB_R      = 4'd4,
        ST_EXEC_ADDR = 4'd5,
        ST_MEM_RD    = 4'd6,
        ST_WB_LD     = 4'd7,
        ST_MEM_WR    = 4'd8,
        ST_EXEC_CBZ  = 4'd9,
        ST_BRANCH_U  = 4'd10,
        ST_TRAP      = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_main_control_opcode_classify.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_opcode_classify
// Combinational opcode classifier for the LEGv8 main control FSM.
// Ports:
//   opcode  in  [10:0]  instruction bits [31:21]
//   is_r    out         ADD / SUB / AND / ORR
//   is_ld   out         LDUR
//   is_st   out         STUR
//   is_cbz  out         CBZ (8-bit prefix match)
//   is_b    out         B   (6-bit prefix match)
//   is_bad  out         none of the above
// Exactly one output is high for any opcode (the patterns do not overlap).
// -----------------------------------------------------------------------------
module multicycle_main_control_opcode_classify
    import legv8_defs_pkg::*;
(
    input  logic [10:0] opcode,
    output logic        is_r,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_cbz,
    output logic        is_b,
    output logic        is_bad
);

    always_comb begin
        is_r   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                 (opcode == OP_AND) || (opcode == OP_ORR);
        is_ld  = (opcode == OP_LDUR);
        is_st  = (opcode == OP_STUR);
        is_cbz = (opcode[10:3] == OP_CBZ_PFX);
        is_b   = (opcode[10:5] == OP_B_PFX);
        is_bad = !(is_r || is_ld || is_st || is_cbz || is_b);
    end

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// Main control FSM for the multi-cycle LEGv8 datapath. Sequences each
// instruction through fetch / decode / execute / memory / writeback, drives
// ALUOp to ALU control plus every datapath enable, and counts retired
// instructions (one per cycle with PCWrite high).
// Ports:
//   CLK, Reset         clock, synchronous active-high reset
//   Opcode [10:0]      instr[31:21], valid from DECODE onward
//   Zero               ALU zero flag, used in EXEC_CBZ only
//   MemReady           data memory completes the current access this cycle
//   ALUOp [1:0]        00 addr add, 01 CBZ pass, 10 R-type
//   ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite,
//   IRWrite, PCWrite, PCSrc   datapath controls
//   Illegal            sticky trap flag (high while in TRAP)
//   InstrCount         retired-instruction count, wraps silently
//   DbgState [3:0]     current FSM state (state_t encoding)
//
// Memory handshake: MemRead (MEM_RD) or MemWrite (MEM_WR) is a request held
// high every cycle until MemReady is sampled high; the access completes in
// that same cycle and the FSM leaves the memory state on the next edge.
// MemReady is ignored outside the memory states. If MemReady stays low for
// MEM_TIMEOUT consecutive cycles the FSM traps instead; MemReady high in the
// last allowed cycle still completes normally.
// -----------------------------------------------------------------------------
module multicycle_main_control
    import legv8_defs_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15   // legal range 1..255
)
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic [10:0]      Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic             Reg2Loc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       DbgState
);

    // Count value reached on the MEM_TIMEOUT-th consecutive low cycle
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_r, is_ld, is_st, is_cbz, is_b, is_bad;

    multicycle_main_control_opcode_classify u_classify (
        .opcode (Opcode),
        .is_r   (is_r),
        .is_ld  (is_ld),
        .is_st  (is_st),
        .is_cbz (is_cbz),
        .is_b   (is_b),
        .is_bad (is_bad)
    );

    assign DbgState = state;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_RST;
            wait_cnt   <= '0;
            InstrCount <= '0;
        end else begin
            // PCWrite is only ever high on an instruction's final cycle
            if (PCWrite) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end

            case (state)
                ST_RST:    state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    if (is_bad)              state <= ST_TRAP;
                    else if (is_r)           state <= ST_EXEC_R;
                    else if (is_ld || is_st) state <= ST_EXEC_ADDR;
                    else if (is_cbz)         state <= ST_EXEC_CBZ;
                    else if (is_b)           state <= ST_BRANCH_U;
                    else                     state <= ST_TRAP;
                end
                ST_EXEC_R: state <= ST_WB_R;
                ST_WB_R:   state <= ST_FETCH;
                ST_EXEC_ADDR: begin
                    // Entry into either memory state restarts the wait count
                    wait_cnt <= '0;
                    state    <= is_st ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    if (MemReady) begin
                        state <= (state == ST_MEM_RD) ? ST_WB_LD : ST_FETCH;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WB_LD:    state <= ST_FETCH;
                ST_EXEC_CBZ: state <= ST_FETCH;
                ST_BRANCH_U: state <= ST_FETCH;
                ST_TRAP:     state <= ST_TRAP;
                default:     state <= ST_TRAP;
            endcase
        end
    end

    // Moore decode of the current state; PCWrite/PCSrc in EXEC_CBZ and
    // PCWrite in MEM_WR also look at Zero / MemReady in the same cycle.
    always_comb begin
        ALUOp    = ALUOP_ADDR;
        ALUSrc   = 1'b0;
        Reg2Loc  = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Illegal  = 1'b0;
        case (state)
            ST_FETCH:  IRWrite = 1'b1;
            ST_EXEC_R: ALUOp = ALUOP_RTYPE;
            ST_WB_R: begin
                ALUOp    = ALUOP_RTYPE;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            ST_EXEC_ADDR: begin
                ALUSrc  = 1'b1;
                Reg2Loc = is_st;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                ALUSrc  = 1'b1;
            end
            ST_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                PCWrite  = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                Reg2Loc  = 1'b1;
                ALUSrc   = 1'b1;
                PCWrite  = MemReady;
            end
            ST_EXEC_CBZ: begin
                ALUOp   = ALUOP_CBZ;
                Reg2Loc = 1'b1;
                PCWrite = 1'b1;
                PCSrc   = Zero;
            end
            ST_BRANCH_U: begin
                PCWrite = 1'b1;
                PCSrc   = 1'b1;
            end
            ST_TRAP:   Illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
// Directed bench for multicycle_main_control. Instruction-level driver tasks
// describe each instruction as its sequence of per-cycle control vectors and
// push one expectation per cycle into exp_q; a single compare process checks
// every cycle on the falling edge. Two instances share the stimulus: the
// default one and a CNT_W = 2 one for counter wrap. Literal pins queued by the
// driver are checked by the same compare process.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

    localparam int W       = 30;   // {ctl[11:0], cnt[15:0], small_cnt[1:0]}
    localparam int TIMEOUT = 15;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010111010;

    // ctl bits: [11:10] ALUOp, 9 ALUSrc, 8 Reg2Loc, 7 MemtoReg, 6 RegWrite,
    // 5 MemRead, 4 MemWrite, 3 IRWrite, 2 PCWrite, 1 PCSrc, 0 Illegal
    localparam logic [11:0] V_RST      = 12'h000;
    localparam logic [11:0] V_FETCH    = 12'h008;
    localparam logic [11:0] V_DEC      = 12'h000;
    localparam logic [11:0] V_EXR      = 12'h800;
    localparam logic [11:0] V_WBR      = 12'h844;
    localparam logic [11:0] V_EXA_LD   = 12'h200;
    localparam logic [11:0] V_EXA_ST   = 12'h300;
    localparam logic [11:0] V_MRD      = 12'h220;
    localparam logic [11:0] V_WBLD     = 12'h0C4;
    localparam logic [11:0] V_MWR_WAIT = 12'h310;
    localparam logic [11:0] V_MWR_DONE = 12'h314;
    localparam logic [11:0] V_CBZ      = 12'h504;
    localparam logic [11:0] V_B        = 12'h006;
    localparam logic [11:0] V_TRAP     = 12'h001;

    localparam logic [3:0] P_CNT    = 4'd0;
    localparam logic [3:0] P_SCNT   = 4'd1;
    localparam logic [3:0] P_ILL    = 4'd2;
    localparam logic [3:0] P_MEMW   = 4'd3;
    localparam logic [3:0] P_MRLAST = 4'd4;
    localparam logic [3:0] P_IRW    = 4'd5;

    // ---------------- clock / reset / DUTs ----------------
    logic        CLK = 1'b0;
    logic        Reset;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemReady;

    logic [1:0]  ALUOp;
    logic        ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        IRWrite, PCWrite, PCSrc, Illegal;
    logic [15:0] InstrCount;
    logic [3:0]  DbgState;

    logic [1:0]  w_ALUOp;
    logic        w_ALUSrc, w_Reg2Loc, w_MemtoReg, w_RegWrite, w_MemRead, w_MemWrite;
    logic        w_IRWrite, w_PCWrite, w_PCSrc, w_Illegal;
    logic [1:0]  w_InstrCount;
    logic [3:0]  w_DbgState;

    always #5 CLK = ~CLK;

    multicycle_main_control #(.CNT_W(16), .MEM_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Illegal(Illegal),
        .InstrCount(InstrCount), .DbgState(DbgState)
    );

    multicycle_main_control #(.CNT_W(2), .MEM_TIMEOUT(TIMEOUT)) dut_w (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .ALUOp(w_ALUOp), .ALUSrc(w_ALUSrc), .Reg2Loc(w_Reg2Loc), .MemtoReg(w_MemtoReg),
        .RegWrite(w_RegWrite), .MemRead(w_MemRead), .MemWrite(w_MemWrite),
        .IRWrite(w_IRWrite), .PCWrite(w_PCWrite), .PCSrc(w_PCSrc), .Illegal(w_Illegal),
        .InstrCount(w_InstrCount), .DbgState(w_DbgState)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [19:0]  pin_q[$];      // {id[3:0], value[15:0]}
    logic [15:0]  model_cnt;     // retired instructions per the model
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;

    function automatic string pin_name(input logic [3:0] id);
        case (id)
            P_CNT:    return "instr_count";
            P_SCNT:   return "instr_count_w2";
            P_ILL:    return "illegal";
            P_MEMW:   return "memwrite";
            P_MRLAST: return "memread_run";
            P_IRW:    return "irwrite";
            default:  return "unknown";
        endcase
    endfunction

    // ---------------- compare process ----------------
    initial begin : compare
        logic [W-1:0] e;
        logic [11:0]  got, got_w;
        logic [19:0]  p;
        logic [15:0]  act;
        int           mr_run;
        int           mr_last;
        mr_run  = 0;
        mr_last = 0;
        forever begin
            @(negedge CLK);
            cyc = cyc + 1;
            if (MemRead === 1'b1) begin
                mr_run = mr_run + 1;
            end else if (mr_run != 0) begin
                mr_last = mr_run;
                mr_run  = 0;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got   = {ALUOp, ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite,
                         IRWrite, PCWrite, PCSrc, Illegal};
                got_w = {w_ALUOp, w_ALUSrc, w_Reg2Loc, w_MemtoReg, w_RegWrite, w_MemRead,
                         w_MemWrite, w_IRWrite, w_PCWrite, w_PCSrc, w_Illegal};
                total = total + 1;
                if (got !== e[29:18]) begin
                    bad = bad + 1;
                    $display("FAIL ctl cyc=%0d got=%03h exp=%03h", cyc, got, e[29:18]);
                end
                total = total + 1;
                if (InstrCount !== e[17:2]) begin
                    bad = bad + 1;
                    $display("FAIL instr_count cyc=%0d got=%0d exp=%0d", cyc, InstrCount, e[17:2]);
                end
                total = total + 1;
                if (got_w !== e[29:18]) begin
                    bad = bad + 1;
                    $display("FAIL ctl_w2 cyc=%0d got=%03h exp=%03h", cyc, got_w, e[29:18]);
                end
                total = total + 1;
                if (w_InstrCount !== e[1:0]) begin
                    bad = bad + 1;
                    $display("FAIL instr_count_w2 cyc=%0d got=%0d exp=%0d", cyc, w_InstrCount, e[1:0]);
                end
            end
            while (pin_q.size() > 0) begin
                p = pin_q.pop_front();
                case (p[19:16])
                    P_CNT:    act = InstrCount;
                    P_SCNT:   act = {14'd0, w_InstrCount};
                    P_ILL:    act = {15'd0, Illegal};
                    P_MEMW:   act = {15'd0, MemWrite};
                    P_MRLAST: act = 16'(mr_last);
                    P_IRW:    act = {15'd0, IRWrite};
                    default:  act = 16'hxxxx;
                endcase
                total = total + 1;
                if (act !== p[15:0]) begin
                    bad = bad + 1;
                    $display("FAIL pin_%s cyc=%0d got=%0d exp=%0d", pin_name(p[19:16]), cyc, act, p[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pin(input logic [3:0] id, input logic [15:0] val);
        pin_q.push_back({id, val});
    endtask

    // One clock cycle: apply inputs, record what this cycle must look like.
    task automatic step(input logic [11:0] ctl, input logic mr, input logic z);
        MemReady = mr;
        Zero     = z;
        exp_q.push_back({ctl, model_cnt, model_cnt[1:0]});
        if (ctl[2]) model_cnt = model_cnt + 16'd1;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        MemReady = 1'b0;
        Zero     = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset     = 1'b0;
        model_cnt = '0;
        pin(P_CNT, 16'd0);
        pin(P_ILL, 16'd0);
        pin(P_IRW, 16'd0);
        step(V_RST, 1'b0, 1'b0);
    endtask

    task automatic instr_r(input logic [10:0] op);
        Opcode = op;
        step(V_FETCH, 1'b0, 1'b0);
        step(V_DEC,   1'b0, 1'b0);
        step(V_EXR,   1'b1, 1'b1);   // MemReady/Zero are don't-cares here
        step(V_WBR,   1'b0, 1'b0);
    endtask

    task automatic instr_ld(input int nwait);
        Opcode = OP_LDUR;
        step(V_FETCH,  1'b0, 1'b0);
        step(V_DEC,    1'b0, 1'b0);
        step(V_EXA_LD, 1'b0, 1'b0);
        for (int i = 0; i < nwait; i++) step(V_MRD, 1'b0, 1'b0);
        step(V_MRD,    1'b1, 1'b0);
        step(V_WBLD,   1'b0, 1'b0);
    endtask

    task automatic instr_st(input int nwait);
        Opcode = OP_STUR;
        step(V_FETCH,  1'b0, 1'b0);
        step(V_DEC,    1'b0, 1'b0);
        step(V_EXA_ST, 1'b0, 1'b0);
        for (int i = 0; i < nwait; i++) step(V_MWR_WAIT, 1'b0, 1'b0);
        step(V_MWR_DONE, 1'b1, 1'b0);
    endtask

    task automatic instr_st_timeout(input int ntrap);
        Opcode = OP_STUR;
        step(V_FETCH,  1'b0, 1'b0);
        step(V_DEC,    1'b0, 1'b0);
        step(V_EXA_ST, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) step(V_MWR_WAIT, 1'b0, 1'b0);
        for (int i = 0; i < ntrap; i++) step(V_TRAP, 1'b1, 1'b0);
    endtask

    task automatic instr_cbz(input logic z);
        Opcode = OP_CBZ;
        step(V_FETCH, 1'b0, ~z);
        step(V_DEC,   1'b0, ~z);
        step(V_CBZ | (z ? 12'h002 : 12'h000), 1'b0, z);
    endtask

    task automatic instr_b();
        Opcode = OP_B;
        step(V_FETCH, 1'b0, 1'b0);
        step(V_DEC,   1'b0, 1'b0);
        step(V_B,     1'b0, 1'b0);
    endtask

    task automatic instr_bad(input logic [10:0] op, input int ntrap);
        Opcode = op;
        step(V_FETCH, 1'b0, 1'b0);
        step(V_DEC,   1'b0, 1'b0);
        for (int i = 0; i < ntrap; i++) step(V_TRAP, 1'b1, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        Opcode    = '0;
        model_cnt = '0;
        do_reset();

        // R-type group: 4 cycles each
        instr_r(OP_ADD);
        pin(P_CNT, 16'd1);
        instr_r(OP_SUB);
        instr_r(OP_AND);
        instr_r(OP_ORR);

        // LDUR with 3 wait cycles: MemRead high for 4 cycles, 8 cycles total
        instr_ld(3);
        pin(P_MRLAST, 16'd4);
        pin(P_CNT, 16'd5);
        pin(P_IRW, 16'd1);
        instr_ld(0);
        instr_st(0);
        instr_st(2);

        // CBZ taken then not taken, then unconditional branch
        instr_cbz(1'b1);
        instr_cbz(1'b0);
        pin(P_CNT, 16'd10);
        instr_b();

        // MemReady arrives on the last allowed cycle: normal retire
        instr_st(TIMEOUT - 1);
        pin(P_CNT, 16'd12);

        // MemReady never arrives: trap after TIMEOUT low cycles
        instr_st_timeout(5);
        pin(P_ILL, 16'd1);
        pin(P_MEMW, 16'd0);
        step(V_TRAP, 1'b1, 1'b0);

        // Counter wrap on the 2-bit instance
        do_reset();
        repeat (4) instr_b();
        pin(P_SCNT, 16'd0);
        pin(P_CNT, 16'd4);
        instr_r(OP_ADD);

        // Illegal opcode traps from DECODE and stays there
        instr_bad(11'b11111111111, 20);
        pin(P_ILL, 16'd1);
        step(V_TRAP, 1'b1, 1'b0);

        // Reset clears the trap; fetch resumes
        do_reset();
        instr_r(OP_ADD);

        // Near-miss of ADD is illegal
        instr_bad(11'b10001011001, 3);

        // Reset in the middle of a memory wait
        do_reset();
        Opcode = OP_LDUR;
        step(V_FETCH,  1'b0, 1'b0);
        step(V_DEC,    1'b0, 1'b0);
        step(V_EXA_LD, 1'b0, 1'b0);
        step(V_MRD,    1'b0, 1'b0);
        step(V_MRD,    1'b0, 1'b0);
        do_reset();
        instr_ld(1);
        pin(P_CNT, 16'd1);
        pin(P_SCNT, 16'd1);
        Opcode = OP_ADD;
        step(V_FETCH, 1'b0, 1'b0);

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle LEGv8 datapath. Sits directly upstream of ALU control.
- Decodes the 11-bit instruction opcode from the instruction register. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ALUOp[1:0] to ALU control and all datapath enables.
- Handles a ready/wait handshake with data memory, and retires instructions into a counter.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: consecutive MemReady-low cycles in a memory state before trapping. Legal range 1..255.

Ports:
- CLK input 1: clock. All state changes on the rising edge.
- Reset input 1: synchronous, active-high reset.
- Opcode input 11: instruction bits [31:21] from the instruction register. Valid from DECODE onward.
- Zero input 1: ALU zero flag. Sampled in EXEC_CBZ only.
- MemReady input 1: data memory completes the current read or write this cycle.
- ALUOp output 2: 00 = address add, 01 = pass/compare (CBZ), 10 = R-type (funct taken from Opcode).
- ALUSrc output 1: 1 = sign-extended immediate, 0 = register.
- Reg2Loc output 1: 1 = Rt field selects read register 2.
- MemtoReg output 1: 1 = write-back data comes from memory.
- RegWrite output 1: register file write enable.
- MemRead output 1: data memory read request.
- MemWrite output 1: data memory write request.
- IRWrite output 1: instruction register load.
- PCWrite output 1: PC load enable.
- PCSrc output 1: 0 = PC+4, 1 = branch target.
- Illegal output 1: sticky trap flag.
- InstrCount output CNT_W: count of retired instructions.

Behaviour:
- States:
  - RST, FETCH, DECODE
  - EXEC_R, WB_R
  - EXEC_ADDR, MEM_RD, WB_LD, MEM_WR
  - EXEC_CBZ, BRANCH_U
  - TRAP
- Reset:
  - State becomes RST; InstrCount = 0; Illegal = 0; wait counter = 0.
  - RST drives every output to 0.
  - RST → FETCH unconditionally. Reset applies from any state, including mid-memory-wait and TRAP.
- Output timing: outputs are decoded from the current state (Moore), except PCWrite/PCSrc in EXEC_CBZ and PCWrite in MEM_WR, which are Mealy. Any output not listed for a state is 0.
- FETCH:
  - IRWrite = 1.
  - → DECODE.
- DECODE: classify Opcode.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXEC_R.
  - LDUR 11111000010, STUR 11111000000 → EXEC_ADDR.
  - Opcode[10:3] = 10110100 (CBZ) → EXEC_CBZ.
  - Opcode[10:5] = 000101 (B) → BRANCH_U.
  - Anything else → TRAP.
- R-type path (4 cycles):
  - EXEC_R: ALUOp = 10, ALUSrc = 0, Reg2Loc = 0.
  - WB_R: ALUOp = 10, RegWrite = 1, MemtoReg = 0, PCWrite = 1, PCSrc = 0. → FETCH.
- EXEC_ADDR:
  - ALUOp = 00, ALUSrc = 1. Reg2Loc = 1 when Opcode is STUR.
  - → MEM_RD for LDUR, → MEM_WR for STUR.
- MEM_RD:
  - MemRead = 1, ALUOp = 00, ALUSrc = 1, held until MemReady.
  - MemReady = 1 → WB_LD.
- WB_LD:
  - RegWrite = 1, MemtoReg = 1, PCWrite = 1, PCSrc = 0.
  - → FETCH. LDUR takes 5 cycles minimum.
- MEM_WR:
  - MemWrite = 1, Reg2Loc = 1, ALUOp = 00, ALUSrc = 1, held until MemReady.
  - In the MemReady cycle: PCWrite = 1, PCSrc = 0, → FETCH. STUR takes 4 cycles minimum.
- Memory wait counter:
  - Cleared on entry to MEM_RD/MEM_WR. Increments on each cycle there with MemReady = 0.
  - When the count equals MEM_TIMEOUT and MemReady = 0 → TRAP.
  - MemReady = 1 in the same cycle always wins (normal completion).
- EXEC_CBZ:
  - ALUOp = 01, Reg2Loc = 1, ALUSrc = 0, PCWrite = 1, PCSrc = Zero.
  - → FETCH. 3 cycles.
- BRANCH_U:
  - PCWrite = 1, PCSrc = 1.
  - → FETCH. 3 cycles.
- TRAP:
  - Illegal = 1; all write/request outputs = 0.
  - Remains in TRAP until Reset.
- InstrCount:
  - Increments by 1 on every cycle with PCWrite = 1.
  - Wraps modulo 2^CNT_W with no flag.
  - Never increments in RST or TRAP.
- MemRead and MemWrite are never both 1. Neither is asserted outside MEM_RD/MEM_WR.

Decomposition:
- Shared include file legv8_defs:
  - opcode constants (full 11-bit R/D patterns, CBZ 8-bit prefix, B 6-bit prefix)
  - ALUOp encodings (00/01/10)
  - state encoding localparams
- Same file is used by the ALU control block.
- One natural sub-module: opcode_classify.
  - Combinational: Opcode → one-hot {is_r, is_ld, is_st, is_cbz, is_b, is_bad}.
  - FSM instantiates it.

Test Plan:
- Reset for 2 cycles, release → RST outputs all 0 for one cycle after release, then IRWrite = 1 in FETCH; InstrCount = 0.
- ADD (10001011000) → FETCH, DECODE, EXEC_R (ALUOp = 10), WB_R (RegWrite = 1, PCWrite = 1, PCSrc = 0); InstrCount 0 → 1 after 4 cycles.
- LDUR with MemReady low for 3 cycles then high → MemRead = 1 for 4 consecutive cycles, then WB_LD with MemtoReg = 1, RegWrite = 1; 8 cycles total.
- CBZ twice, Zero = 1 then Zero = 0 → PCSrc = 1 then 0 in EXEC_CBZ, PCWrite = 1 both times; each instruction takes 3 cycles; InstrCount +2.
- STUR with MemReady held low, MEM_TIMEOUT = 15 → TRAP after 15 wait cycles; Illegal = 1; MemWrite drops to 0; repeat with MemReady = 1 on the 15th cycle → normal retire instead.
- Opcode 11111111111 → TRAP from DECODE, Illegal stays 1 for 20 cycles; Reset → Illegal = 0, InstrCount = 0, FETCH resumes. CNT_W = 2 with 4 retirements → InstrCount wraps to 0.
